// File: rtl/core_pkg.sv
// core_pkg: shared pipeline-control state encoding and RV32I opcode constants
package core_pkg;
  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } ctrl_state_t;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: free-running wrapping event counter
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_controller.sv
// pipeline_controller: per-stage enables/flushes from hazards and the data-memory handshake
module pipeline_controller
  import core_pkg::*;
#(
  parameter int START_DELAY = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hd_run,
  input  logic             branch_kill,
  input  logic             jump_kill,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int BOOT_W = $clog2(START_DELAY + 1);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  ctrl_state_t       state, state_nxt;
  logic [BOOT_W-1:0] boot_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [4:0]        en;
  logic [2:0]        fl;
  logic              mem_stall;
  assign mem_stall = dmem_req & ~dmem_ack;
  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem}
  always_comb begin
    state_nxt = state;
    en = 5'b00000;
    fl = 3'b000;
    case (state)
      BOOT: begin
        en = 5'b01111;
        fl = 3'b111;
        state_nxt = (boot_cnt == BOOT_W'(START_DELAY - 1)) ? RUN : BOOT;
      end
      RUN: begin
        en = mem_stall ? 5'b00000 : (!branch_kill && !jump_kill && !hd_run) ? 5'b00111 : 5'b11111;
        fl = mem_stall ? 3'b000 : branch_kill ? 3'b111 : jump_kill ? 3'b110 : !hd_run ? 3'b010 : 3'b000;
        state_nxt = mem_stall ? MEM_WAIT : RUN;
      end
      MEM_WAIT:
        state_nxt = dmem_ack ? RUN : (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT;
      ERROR: state_nxt = ERROR;
      default: state_nxt = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= BOOT;
      boot_cnt <= '0;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
      wait_cnt <= (state == MEM_WAIT && !dmem_ack) ? wait_cnt + 1'b1 : '0;
      mem_err  <= mem_err | (state_nxt == ERROR);
    end
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
  assign {if_id_flush, id_ex_flush, ex_mem_flush} = fl;
  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     ((state == RUN || state == MEM_WAIT) && !pc_en),
    .count   (stall_cnt)
  );
  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (state == RUN && |fl),
    .count   (flush_cnt)
  );
endmodule
